load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and dataMemory; the core issues a request and dataMemory serves it.
- Converts byte, halfword and word load/store requests into the word-only accesses that dataMemory supports.
- Sub-word stores use a read-modify-write sequence; sub-word loads are sign- or zero-extended.
- Misaligned and out-of-range requests are rejected without touching memory; the core stalls on req_ready/resp_valid.

Parameters:
- MEM_WORDS, 256: number of 32-bit words in dataMemory. A word index at or above this value is out of range.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_err  out  1  qualifies resp_valid: misaligned, reserved size, or out of range.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- mem_read  out  1  drives dataMemory memRead.
- mem_write  out  1  drives dataMemory memWrite.
- mem_address  out  32  word-aligned address: {addr_q[31:2], 2'b00}.
- mem_write_data  out  32  drives dataMemory writeData.
- mem_read_data  in  32  from dataMemory readData; combinational and valid in the same cycle as mem_read.

Behaviour:
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0, resp_err = 0, resp_rdata = 0; mem_read = 0, mem_write = 0; mem_address = 0, mem_write_data = 0.
- All outputs are decoded from registered state and registers only. No combinational path exists from req_* to mem_*.
- Acceptance: when req_valid & req_ready, the unit captures write, size, unsigned, addr and wdata into *_q registers.
- Error check at acceptance, any one of these is an error:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11;
  - addr[31:2] >= MEM_WORDS.
  - Error path: next state is RESP with err_q = 1; no mem_read or mem_write is issued.
- Otherwise the next state is ACCESS.
- ACCESS:
  - Load: mem_read = 1. Capture the extracted and extended lane into rdata_q. Next state is RESP.
  - Word store: mem_write = 1, mem_write_data = wdata_q. Next state is RESP.
  - Byte/half store: mem_read = 1. Capture the merged word into merge_q. Next state is WRITE.
- WRITE: mem_write = 1, mem_write_data = merge_q. Next state is RESP.
- RESP:
  - resp_valid = 1, resp_err = err_q, resp_rdata = rdata_q for loads, else 0.
  - Next state is IDLE.
  - A new request is accepted only in the following IDLE cycle; there is no back-to-back acceptance in RESP.
- Lane rules (little-endian):
  - byte lane = addr[1:0], i.e. bits [8*a+7 : 8*a];
  - half lane = addr[1], i.e. bits [16*h+15 : 16*h].
  - Merge replaces only the addressed lane with req_wdata[7:0] or [15:0]; the other bytes keep the value read.
- Extension:
  - signed byte: {24{b[7]}, b};
  - unsigned byte: {24'b0, b};
  - half loads follow the same rule with 16 bits.
- Latency from acceptance edge to resp_valid:
  - load / word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Reset mid-operation:
  - state returns to IDLE immediately and mem_write drops asynchronously;
  - a pending RMW write is abandoned, so the memory word is left unmodified;
  - no resp_valid is produced for the aborted request.
- req_* changes while the unit is not in IDLE are ignored.

Test Plan:
- Word store then load:
  - store addr 0x10, data 0xDEADBEEF -> mem_write for 1 cycle, address 0x10, resp 2 cycles after acceptance;
  - load 0x10 -> resp_rdata 0xDEADBEEF, resp_err 0.
- Byte store RMW:
  - word 0x10 holds 0xDEADBEEF; sb 0x13 with data 0x12 -> 0x12ADBEEF written in the WRITE cycle;
  - lb 0x13 -> 0x00000012; lb 0x12 -> 0xFFFFFFAD; lbu 0x12 -> 0x000000AD.
- Halfword paths:
  - sh 0x12 with data 0x8001 -> word becomes 0x8001BEEF;
  - lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
- Errors:
  - lw 0x11, lh 0x13, size 11, and lw 0x400 (with MEM_WORDS = 256) -> each gives resp_valid with resp_err = 1 one cycle after acceptance;
  - mem_read and mem_write stay 0 throughout.
- Handshake:
  - req_valid held high continuously -> req_ready low in ACCESS, WRITE and RESP;
  - the second request is accepted exactly one cycle after the first resp_valid;
  - changing req_addr mid-request has no effect.
- Reset during RMW:
  - assert rst_n = 0 in the WRITE cycle of sb 0x10 -> mem_write falls without waiting for a clock edge;
  - memory word unchanged, no resp_valid, req_ready = 1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit bridging the core to a word-only dataMemory.
// Sub-word stores use read-modify-write; sub-word loads are sign/zero-extended.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle strobe in RESP.

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        req_err;
    logic        accept;
    logic        word_store;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept     = (state_q == IDLE) && req_valid;
    assign word_store = write_q && (size_q == SZ_WORD);
    assign dbg_state  = state_q;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                               req_err = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])            req_err = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))       req_err = 1'b1;
    end

    always_comb begin
        lane_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        lane_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {24'b0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: load_ext = unsigned_q ? {16'b0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            default: load_ext = mem_read_data;
        endcase
        // Only the addressed lane is replaced; other bytes keep the value just read.
        merged = mem_read_data;
        if (size_q == SZ_BYTE)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (size_q == SZ_HALF)
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = (write_q && !word_store) ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        resp_err       = (state_q == RESP) && err_q;
        resp_rdata     = ((state_q == RESP) && !write_q) ? rdata_q : 32'b0;
        mem_read       = (state_q == ACCESS) && !word_store;
        mem_write      = ((state_q == ACCESS) && word_store) || (state_q == WRITE);
        mem_address    = {addr_q[31:2], 2'b00};
        mem_write_data = 32'b0;
        if (state_q == WRITE)
            mem_write_data = merge_q;
        else if ((state_q == ACCESS) && word_store)
            mem_write_data = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'b0;
            merge_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                err_q      <= req_err;
                rdata_q    <= 32'b0;
            end
            if (state_q == ACCESS) begin
                if (!write_q)
                    rdata_q <= load_ext;
                else if (!word_store)
                    merge_q <= merged;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests
// checked against an arithmetic model of memory and load/store semantics.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tb_mem  [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    logic [31:0] exp_q [$];

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .dbg_state(dbg_state)
    );

    // clock / reset / memory environment
    always #5 clk = ~clk;
    assign mem_read_data = tb_mem[mem_address[9:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_address[9:2]] <= mem_write_data;

    // Reference: what a request should do, from the architectural rules only.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd, output int lat);
        int unsigned idx, sh;
        logic [31:0] mask, v;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
              || (a[31:2] >= 30'd256);
        rd = 32'h0;
        lat = 1;
        if (err) return;
        idx  = a[9:2];
        sh   = 8 * a[1:0];
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (w) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (sz == 2'd2) ? 2 : 3;
        end else begin
            v = (ref_mem[idx] >> sh) & mask;
            if (!u && sz == 2'd0 && v[7])  v = v | ~mask;
            if (!u && sz == 2'd1 && v[15]) v = v | ~mask;
            rd  = v;
            lat = 2;
        end
    endfunction

    // driver: issue one request, observe until resp_valid, check everything
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string name, output logic [31:0] rdata_o);
        logic        e_err, got, g_err;
        logic [31:0] e_rd, g_rd;
        int          e_lat, lat, rd_n, wr_n, bad_addr, guard;
        model(w, sz, u, a, wd, e_err, e_rd, e_lat);
        exp_q.push_back(e_rd);
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL %s ready_timeout: got req_ready=%0b expected 1", name, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        got = 0; lat = 0; rd_n = 0; wr_n = 0; bad_addr = 0; g_err = 0; g_rd = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_read)  rd_n++;
            if (mem_write) wr_n++;
            if ((mem_read || mem_write) && mem_address !== {a[31:2], 2'b00}) bad_addr++;
            if (resp_valid) begin got = 1; lat = c; g_err = resp_err; g_rd = resp_rdata; end
        end
        e_rd = exp_q.pop_front();
        rdata_o = g_rd;
        checks++;
        if (!got || lat != e_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d (0 = no resp)", name, lat, e_lat);
        end
        checks++;
        if (g_err !== e_err) begin
            failures++;
            $display("FAIL %s resp_err: got %0b expected %0b", name, g_err, e_err);
        end
        checks++;
        if (g_rd !== e_rd) begin
            failures++;
            $display("FAIL %s resp_rdata: got %h expected %h", name, g_rd, e_rd);
        end
        checks++;
        if (wr_n != ((w && !e_err) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s mem_write_cycles: got %0d expected %0d", name, wr_n, (w && !e_err) ? 1 : 0);
        end
        checks++;
        if (rd_n != ((!e_err && !(w && sz == 2'd2)) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s mem_read_cycles: got %0d expected %0d", name, rd_n,
                     (!e_err && !(w && sz == 2'd2)) ? 1 : 0);
        end
        checks++;
        if (bad_addr != 0) begin
            failures++;
            $display("FAIL %s mem_address: got %0d bad cycles expected 0", name, bad_addr);
        end
        if (!e_err) begin
            checks++;
            if (tb_mem[a[9:2]] !== ref_mem[a[9:2]]) begin
                failures++;
                $display("FAIL %s mem_word: got %h expected %h", name, tb_mem[a[9:2]], ref_mem[a[9:2]]);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset req_ready", 32'(req_ready), 32'h1);
        check_val("reset resp_valid", 32'(resp_valid), 32'h0);
        check_val("reset resp_err", 32'(resp_err), 32'h0);
        check_val("reset resp_rdata", resp_rdata, 32'h0);
        check_val("reset mem_read", 32'(mem_read), 32'h0);
        check_val("reset mem_write", 32'(mem_write), 32'h0);
        check_val("reset mem_address", mem_address, 32'h0);
        check_val("reset mem_write_data", mem_write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] r;
        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, "sw_0x10", r);
        check_val("sw_0x10 word", tb_mem[4], 32'hDEADBEEF);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, "lw_0x10", r);
        check_val("lw_0x10 value", r, 32'hDEADBEEF);
    endtask

    task automatic test_byte_rmw();
        logic [31:0] r;
        do_req(1, 2'd0, 0, 32'h13, 32'h12, "sb_0x13", r);
        check_val("sb_0x13 word", tb_mem[4], 32'h12ADBEEF);
        do_req(0, 2'd0, 0, 32'h13, 32'h0, "lb_0x13", r);
        check_val("lb_0x13 value", r, 32'h00000012);
        do_req(0, 2'd0, 0, 32'h12, 32'h0, "lb_0x12", r);
        check_val("lb_0x12 value", r, 32'hFFFFFFAD);
        do_req(0, 2'd0, 1, 32'h12, 32'h0, "lbu_0x12", r);
        check_val("lbu_0x12 value", r, 32'h000000AD);
    endtask

    task automatic test_half();
        logic [31:0] r;
        do_req(1, 2'd1, 0, 32'h12, 32'h8001, "sh_0x12", r);
        check_val("sh_0x12 word", tb_mem[4], 32'h8001BEEF);
        do_req(0, 2'd1, 0, 32'h12, 32'h0, "lh_0x12", r);
        check_val("lh_0x12 value", r, 32'hFFFF8001);
        do_req(0, 2'd1, 1, 32'h12, 32'h0, "lhu_0x12", r);
        check_val("lhu_0x12 value", r, 32'h00008001);
    endtask

    task automatic test_errors();
        logic [31:0] r;
        do_req(0, 2'd2, 0, 32'h11, 32'h0, "err_lw_0x11", r);
        do_req(0, 2'd1, 0, 32'h13, 32'h0, "err_lh_0x13", r);
        do_req(1, 2'd3, 0, 32'h10, 32'h5A5A5A5A, "err_size11", r);
        do_req(0, 2'd2, 0, 32'h400, 32'h0, "err_lw_0x400", r);
        do_req(1, 2'd2, 0, 32'h3FC, 32'h01020304, "sw_last_word", r);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, rd_b;
        logic        e_err;
        int          e_lat;
        do_req(1, 2'd2, 0, 32'h20, 32'h11223344, "hs_pre_a", r);
        do_req(1, 2'd2, 0, 32'h24, 32'h55667788, "hs_pre_b", r);
        model(1, 2'd0, 0, 32'h20, 32'hAA, e_err, r, e_lat);
        model(0, 2'd2, 0, 32'h24, 32'h0, e_err, rd_b, e_lat);
        @(negedge clk);
        req_write = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h20; req_wdata = 32'hAA;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_write = 0; req_size = 2'd2; req_addr = 32'h24; req_wdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_val($sformatf("hs_ready_c%0d", c), 32'(req_ready), (c == 4) ? 32'h1 : 32'h0);
            check_val($sformatf("hs_resp_c%0d", c), 32'(resp_valid), (c == 3 || c == 6) ? 32'h1 : 32'h0);
            if (c == 6) check_val("hs_b_rdata", resp_rdata, rd_b);
        end
        req_valid = 1'b0;
        check_val("hs_a_word", tb_mem[8], 32'h112233AA);
        check_val("hs_a_model", tb_mem[8], ref_mem[8]);
    endtask

    task automatic test_reset_rmw();
        logic [31:0] r;
        int          stray;
        do_req(1, 2'd2, 0, 32'h10, 32'hCAFEF00D, "rst_pre", r);
        @(negedge clk);
        req_write = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h10; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rst_access_mem_read", 32'(mem_read), 32'h1);
        @(negedge clk);
        check_val("rst_write_mem_write", 32'(mem_write), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_mem_write", 32'(mem_write), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check_val("rst_no_resp", 32'(stray), 32'h0);
        check_val("rst_req_ready", 32'(req_ready), 32'h1);
        check_val("rst_word_kept", tb_mem[4], 32'hCAFEF00D);
    endtask

    task automatic test_random();
        logic [31:0] r, a;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, $sformatf("rand_%0d", i), r);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_rmw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
